// File: rtl/nested_int_ctrl.sv
// Nesting interrupt controller for the WB stage of the 5-stage pipeline.
// Fixed priority (higher index wins), per-source masks, and an EPC/level
// stack so higher-priority sources can preempt a running handler. A short
// flush window after every take or ERET keeps redirects from colliding.
module nested_int_ctrl #(
    parameter int              NUM_SRC    = 4,
    parameter int              NEST_DEPTH = 4,
    parameter int              PC_W       = 32,
    parameter logic [PC_W-1:0] VEC_BASE   = 'h0000_3000,
    parameter logic [PC_W-1:0] VEC_STRIDE = 'h0000_0100,
    parameter int              FLUSH_CYC  = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] ir_in,
    input  logic               wb_valid,
    input  logic [PC_W-1:0]    wb_next_pc,
    input  logic               eret,
    input  logic               ie_set,
    input  logic               ie_clr,
    input  logic               mask_we,
    input  logic [NUM_SRC-1:0] mask_wdata,
    output logic               int_request,
    output logic [PC_W-1:0]    int_next_pc,
    output logic [PC_W-1:0]    eret_pc,
    output logic               eret_redirect,
    output logic [NUM_SRC-1:0] int_waiting,
    output logic [4:0]         cur_level,
    output logic               nest_full,
    output logic               eret_err
);

    localparam int SPW = $clog2(NEST_DEPTH + 1);
    localparam int IW  = (NEST_DEPTH > 1) ? $clog2(NEST_DEPTH) : 1;
    localparam int SW  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int FW  = (FLUSH_CYC > 0) ? $clog2(FLUSH_CYC + 1) : 1;

    localparam logic [SPW-1:0] DEPTH_V = SPW'(NEST_DEPTH);
    localparam logic [FW-1:0]  FLUSH_V = FW'(FLUSH_CYC);

    logic [NUM_SRC-1:0] ir_d;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] mask;
    logic               ie;
    logic [SPW-1:0]     sp;
    logic [FW-1:0]      flush_cnt;
    logic [PC_W-1:0]    epc_stk [NEST_DEPTH];
    logic [4:0]         lvl_stk [NEST_DEPTH];

    logic               cand_valid;
    logic [SW-1:0]      cand_idx;
    logic [4:0]         cand_p;
    logic               take;
    logic               eret_pop;
    logic               eret_bad;
    logic [NUM_SRC-1:0] pend_set;
    logic [NUM_SRC-1:0] pend_clr;
    logic [IW-1:0]      push_idx;
    logic [IW-1:0]      pop_idx;
    logic [PC_W-1:0]    vec_pc;

    assign pend_set    = ir_in & ~ir_d;
    assign push_idx    = IW'(sp);
    assign pop_idx     = IW'(sp - SPW'(1));
    assign int_waiting = pending;
    assign nest_full   = (sp == DEPTH_V);

    // Pick the highest-index pending and unmasked source, then decide take/ERET.
    always_comb begin
        cand_valid = 1'b0;
        cand_idx   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (pending[i] && mask[i]) begin
                cand_valid = 1'b1;
                cand_idx   = SW'(i);
            end
        end
        cand_p   = 5'(cand_idx) + 5'd1;
        vec_pc   = VEC_BASE + PC_W'(cand_idx) * VEC_STRIDE;
        eret_pop = eret && (sp != '0);
        eret_bad = eret && (sp == '0);
        // ERET wins over a take; the take is retried after the flush window.
        take     = cand_valid && ie && wb_valid && (cand_p > cur_level) &&
                   (sp < DEPTH_V) && (flush_cnt == '0) && !eret;
        pend_clr = take ? (NUM_SRC'(1) << cand_idx) : '0;
    end

    // Edge capture, pending bits (a new edge beats a same-cycle clear), mask and IE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ir_d    <= '0;
            pending <= '0;
            mask    <= '1;
            ie      <= 1'b1;
        end else begin
            ir_d    <= ir_in;
            pending <= (pending & ~pend_clr) | pend_set;
            if (mask_we)
                mask <= mask_wdata;
            if (take)
                ie <= 1'b0;
            else if (eret_pop)
                ie <= 1'b1;
            else if (ie_set && ie_clr)
                ie <= 1'b0;
            else if (ie_set)
                ie <= 1'b1;
            else if (ie_clr)
                ie <= 1'b0;
        end
    end

    // EPC/level stack: push the interrupted context on a take, pop on ERET.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp        <= '0;
            cur_level <= '0;
            for (int k = 0; k < NEST_DEPTH; k++) begin
                epc_stk[k] <= '0;
                lvl_stk[k] <= '0;
            end
        end else if (eret_pop) begin
            sp        <= sp - SPW'(1);
            cur_level <= lvl_stk[pop_idx];
        end else if (take) begin
            epc_stk[push_idx] <= wb_next_pc;
            lvl_stk[push_idx] <= cur_level;
            sp                <= sp + SPW'(1);
            cur_level         <= cand_p;
        end
    end

    // Flush guard: reload on any redirect, otherwise count down to zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            flush_cnt <= '0;
        else if (take || eret_pop)
            flush_cnt <= FLUSH_V;
        else if (flush_cnt != '0)
            flush_cnt <= flush_cnt - FW'(1);
    end

    // Registered redirect pulses and their target addresses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            int_request   <= 1'b0;
            eret_redirect <= 1'b0;
            eret_err      <= 1'b0;
            int_next_pc   <= '0;
            eret_pc       <= '0;
        end else begin
            int_request   <= take;
            eret_redirect <= eret_pop;
            eret_err      <= eret_bad;
            if (take)
                int_next_pc <= vec_pc;
            if (eret_pop)
                eret_pc <= epc_stk[pop_idx];
        end
    end

endmodule
